// File: rtl/vanilla_remote_load_resp_buffer.sv
// Remote-load response buffer for the vanilla core.
// Responses coming back from the network endpoint are sorted into an integer
// FIFO and a float FIFO. The head of each FIFO is offered to the core on a
// v/yumi channel. A force flag tells the core that a head has been waiting
// too long and must be written back now.
module vanilla_remote_load_resp_buffer #(
  parameter int data_width_p      = 32,
  parameter int reg_addr_width_p  = 5,
  parameter int els_p             = 2,
  parameter int force_threshold_p = 4
) (
  input  logic                        clk_i,
  input  logic                        reset_i,

  input  logic                        resp_v_i,
  input  logic                        resp_float_i,
  input  logic [reg_addr_width_p-1:0] resp_rd_i,
  input  logic [data_width_p-1:0]     resp_data_i,
  output logic                        resp_ready_o,

  output logic                        int_v_o,
  output logic [reg_addr_width_p-1:0] int_rd_o,
  output logic [data_width_p-1:0]     int_data_o,
  output logic                        int_force_o,
  input  logic                        int_yumi_i,

  output logic                        float_v_o,
  output logic [reg_addr_width_p-1:0] float_rd_o,
  output logic [data_width_p-1:0]     float_data_o,
  output logic                        float_force_o,
  input  logic                        float_yumi_i
);

  localparam int ptr_w_lp  = $clog2(els_p);
  localparam int cnt_w_lp  = $clog2(els_p + 1);
  localparam int wait_w_lp = $clog2(force_threshold_p + 1);

  localparam logic [ptr_w_lp-1:0]  ptr_last_lp  = ptr_w_lp'(els_p - 1);
  localparam logic [cnt_w_lp-1:0]  cnt_full_lp  = cnt_w_lp'(els_p);
  localparam logic [wait_w_lp-1:0] wait_sat_lp  = wait_w_lp'(force_threshold_p);

  // Index 0 is the integer queue, index 1 the float queue.
  logic [data_width_p-1:0]     r_data  [2][els_p];
  logic [reg_addr_width_p-1:0] r_rd    [2][els_p];
  logic [ptr_w_lp-1:0]         r_wptr  [2];
  logic [ptr_w_lp-1:0]         r_rptr  [2];
  logic [cnt_w_lp-1:0]         r_count [2];
  logic [wait_w_lp-1:0]        r_wait  [2];

  logic [1:0] w_yumi;
  logic [1:0] w_sel;
  logic [1:0] w_full;
  logic [1:0] w_empty;
  logic [1:0] w_v;
  logic [1:0] w_force;
  logic [1:0] w_enq;
  logic [1:0] w_deq;
  logic       w_ready;

  // Pointers wrap at els_p, which need not be a power of two.
  function automatic logic [ptr_w_lp-1:0] f_ptr_inc(input logic [ptr_w_lp-1:0] ptr);
    return (ptr == ptr_last_lp) ? '0 : ptr + 1'b1;
  endfunction

  // Queue status, handshakes and force flags, all derived from registered state.
  // NOTE: every signal gets a default at the top so no path can infer a latch.
  always_comb begin
    w_yumi  = {float_yumi_i, int_yumi_i};
    w_sel   = {resp_float_i, ~resp_float_i};
    w_full  = '0;
    w_empty = '0;
    w_v     = '0;
    w_force = '0;
    w_deq   = '0;
    for (int q = 0; q < 2; q++) begin
      w_full[q]  = (r_count[q] == cnt_full_lp);
      w_empty[q] = (r_count[q] == '0);
      w_v[q]     = ~reset_i & ~w_empty[q];
      w_force[q] = w_v[q] & (r_wait[q] == wait_sat_lp);
      w_deq[q]   = w_yumi[q] & w_v[q];
    end
    // Ready looks only at the selected queue's fullness, never at yumi.
    w_ready = ~reset_i & ~w_full[resp_float_i];
    w_enq   = {2{resp_v_i & w_ready}} & w_sel;
  end

  assign resp_ready_o  = w_ready;

  assign int_v_o       = w_v[0];
  assign int_rd_o      = r_rd[0][r_rptr[0]];
  assign int_data_o    = r_data[0][r_rptr[0]];
  assign int_force_o   = w_force[0];

  assign float_v_o     = w_v[1];
  assign float_rd_o    = r_rd[1][r_rptr[1]];
  assign float_data_o  = r_data[1][r_rptr[1]];
  assign float_force_o = w_force[1];

  // Entry storage: written at the tail on an accepted enqueue.
  // NOTE: storage is not reset; an entry is only read when the count says it is valid.
  always_ff @(posedge clk_i) begin
    for (int q = 0; q < 2; q++) begin
      if (w_enq[q]) begin
        r_data[q][r_wptr[q]] <= resp_data_i;
        r_rd[q][r_wptr[q]]   <= resp_rd_i;
      end
    end
  end

  // Pointers, occupancy and head-wait counter for each queue.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    for (int q = 0; q < 2; q++) begin
      if (reset_i) begin
        r_wptr[q]  <= '0;
        r_rptr[q]  <= '0;
        r_count[q] <= '0;
        r_wait[q]  <= '0;
      end else begin
        if (w_enq[q]) r_wptr[q] <= f_ptr_inc(r_wptr[q]);
        if (w_deq[q]) r_rptr[q] <= f_ptr_inc(r_rptr[q]);

        case ({w_enq[q], w_deq[q]})
          2'b10:   r_count[q] <= r_count[q] + cnt_w_lp'(1);
          2'b01:   r_count[q] <= r_count[q] - cnt_w_lp'(1);
          default: r_count[q] <= r_count[q];
        endcase

        // The wait count tracks how long the current head has been ignored.
        if (w_empty[q] || w_deq[q])     r_wait[q] <= '0;
        else if (r_wait[q] != wait_sat_lp) r_wait[q] <= r_wait[q] + wait_w_lp'(1);
      end
    end
  end

endmodule

// File: tb/tb_vanilla_remote_load_resp_buffer.sv
// Self-checking bench for vanilla_remote_load_resp_buffer.
// A behavioural model (two SV queues plus wait counters) predicts every
// output each cycle; accepted responses are pushed onto the model queues and
// popped when the core side consumes them.
module tb_vanilla_remote_load_resp_buffer;

  localparam int DW  = 32;
  localparam int RW  = 5;
  localparam int ELS = 2;
  localparam int THR = 4;

  typedef struct packed {
    logic [RW-1:0] rd;
    logic [DW-1:0] data;
  } ent_t;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic          resp_v_i;
  logic          resp_float_i;
  logic [RW-1:0] resp_rd_i;
  logic [DW-1:0] resp_data_i;
  logic          resp_ready_o;
  logic          int_v_o;
  logic [RW-1:0] int_rd_o;
  logic [DW-1:0] int_data_o;
  logic          int_force_o;
  logic          int_yumi_i;
  logic          float_v_o;
  logic [RW-1:0] float_rd_o;
  logic [DW-1:0] float_data_o;
  logic          float_force_o;
  logic          float_yumi_i;

  vanilla_remote_load_resp_buffer #(
    .data_width_p     (DW),
    .reg_addr_width_p (RW),
    .els_p            (ELS),
    .force_threshold_p(THR)
  ) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .resp_v_i     (resp_v_i),
    .resp_float_i (resp_float_i),
    .resp_rd_i    (resp_rd_i),
    .resp_data_i  (resp_data_i),
    .resp_ready_o (resp_ready_o),
    .int_v_o      (int_v_o),
    .int_rd_o     (int_rd_o),
    .int_data_o   (int_data_o),
    .int_force_o  (int_force_o),
    .int_yumi_i   (int_yumi_i),
    .float_v_o    (float_v_o),
    .float_rd_o   (float_rd_o),
    .float_data_o (float_data_o),
    .float_force_o(float_force_o),
    .float_yumi_i (float_yumi_i)
  );

  always #5 clk_i = ~clk_i;

  // Consuming an empty head is illegal on the core side.
  always @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(int_yumi_i && !int_v_o)) else $error("int yumi without valid");
      assert (!(float_yumi_i && !float_v_o)) else $error("float yumi without valid");
    end
  end

  int   n_tests = 0;
  int   n_fail  = 0;
  ent_t sb_int[$];
  ent_t sb_flt[$];
  int   m_wait_int = 0;
  int   m_wait_flt = 0;
  int   force_low_cycles;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Synchronous reset for n cycles; outputs must be quiet throughout.
  task automatic do_reset(input int n);
    reset_i      = 1'b1;
    resp_v_i     = 1'b0;
    resp_float_i = 1'b0;
    resp_rd_i    = '0;
    resp_data_i  = '0;
    int_yumi_i   = 1'b0;
    float_yumi_i = 1'b0;
    for (int i = 0; i < n; i++) begin
      #1;
      check("rst_int_v",   int_v_o,       1'b0);
      check("rst_flt_v",   float_v_o,     1'b0);
      check("rst_int_frc", int_force_o,   1'b0);
      check("rst_flt_frc", float_force_o, 1'b0);
      check("rst_ready",   resp_ready_o,  1'b0);
      @(posedge clk_i); #1;
    end
    sb_int.delete();
    sb_flt.delete();
    m_wait_int = 0;
    m_wait_flt = 0;
    reset_i = 1'b0;
  endtask

  // One clock cycle: drive inputs, compare every output with the model,
  // then advance the model across the clock edge.
  task automatic cycle(input logic ev, input logic ef, input logic [RW-1:0] rd,
                       input logic [DW-1:0] d, input logic iy, input logic fy);
    logic exp_ready;
    logic acc;
    logic iy_g;
    logic fy_g;
    iy_g = iy && (sb_int.size() != 0);
    fy_g = fy && (sb_flt.size() != 0);
    resp_v_i     = ev;
    resp_float_i = ef;
    resp_rd_i    = rd;
    resp_data_i  = d;
    int_yumi_i   = iy_g;
    float_yumi_i = fy_g;
    #1;
    check("int_v", int_v_o, sb_int.size() != 0);
    if (sb_int.size() != 0) begin
      check("int_rd",   int_rd_o,   sb_int[0].rd);
      check("int_data", int_data_o, sb_int[0].data);
    end
    check("int_force", int_force_o, (sb_int.size() != 0) && (m_wait_int == THR));
    check("flt_v", float_v_o, sb_flt.size() != 0);
    if (sb_flt.size() != 0) begin
      check("flt_rd",   float_rd_o,   sb_flt[0].rd);
      check("flt_data", float_data_o, sb_flt[0].data);
    end
    check("flt_force", float_force_o, (sb_flt.size() != 0) && (m_wait_flt == THR));
    exp_ready = ef ? (sb_flt.size() < ELS) : (sb_int.size() < ELS);
    check("ready", resp_ready_o, exp_ready);
    acc = ev && exp_ready;

    if (iy_g || sb_int.size() == 0) m_wait_int = 0;
    else if (m_wait_int < THR)      m_wait_int++;
    if (fy_g || sb_flt.size() == 0) m_wait_flt = 0;
    else if (m_wait_flt < THR)      m_wait_flt++;

    if (iy_g) void'(sb_int.pop_front());
    if (fy_g) void'(sb_flt.pop_front());
    if (acc) begin
      if (ef) sb_flt.push_back('{rd: rd, data: d});
      else    sb_int.push_back('{rd: rd, data: d});
    end
    @(posedge clk_i); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset then idle.
    do_reset(3);
    cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, '0, '0, 1'b0, 1'b0);

    // Int enqueue, then dequeue; float side stays empty.
    cycle(1'b1, 1'b0, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    idle(1);

    // Fill int queue; third int response refused, float side still ready.
    cycle(1'b1, 1'b0, 5'd1, 32'h0000_0011, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 5'd2, 32'h0000_0022, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 5'd3, 32'h0000_0033, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, '0, '0, 1'b0, 1'b0);
    check("sb_int_full", sb_int.size(), ELS);
    cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    idle(1);

    // Force timing: two float entries, yumi held low.
    cycle(1'b1, 1'b1, 5'd7, 32'hA5A5_0007, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 5'd8, 32'hA5A5_0008, 1'b0, 1'b0);
    force_low_cycles = 1; // the previous cycle already showed the head with force low
    for (int i = 0; i < 6; i++) begin
      #0;
      if (float_force_o === 1'b0) force_low_cycles++;
      cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    end
    check("force_low_cycles", force_low_cycles, THR);
    check("force_held", float_force_o, 1'b1);
    cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    check("next_head_force", float_force_o, 1'b0);
    check("next_head_rd",    float_rd_o,    5'd8);

    // Simultaneous enqueue and dequeue on a one-entry float queue, with wrap.
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b1, 5'(i + 10), 32'hF000_0000 | 32'(i), 1'b0, 1'b1);
      check("sim_depth", sb_flt.size(), 1);
    end
    cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    idle(1);

    // Reset mid-operation with both queues full and forced.
    cycle(1'b1, 1'b0, 5'd21, 32'h1111_0021, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 5'd22, 32'h1111_0022, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 5'd23, 32'h2222_0023, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 5'd24, 32'h2222_0024, 1'b0, 1'b0);
    idle(6);
    check("pre_rst_int_force", int_force_o,   1'b1);
    check("pre_rst_flt_force", float_force_o, 1'b1);
    do_reset(1);
    idle(1);
    cycle(1'b1, 1'b0, 5'd30, 32'hCAFE_0030, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    check("post_rst_alone", int_v_o && !float_v_o && (int_rd_o == 5'd30), 1'b1);
    cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    idle(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
